// File: rtl/write_pointer.sv
// -----------------------------------------------------------------------------
// write_pointer
//   Write-side pointer and flag controller for a dual-clock FIFO. Everything
//   here runs on clk_i. Keeps the binary write address plus the Gray copy that
//   is exported to the read domain, synchronises the read domain's Gray
//   pointer, and derives full / almost-full / fill level / sticky overflow.
//
// Ports
//   clk_i          write-domain clock
//   rst_i          asynchronous reset, active low
//   rd_ptr_i       Gray read pointer from the read domain (async to clk_i)
//   inc_i          write request, one entry per cycle
//   clr_ovf_i      clears overflow_o (a same-cycle set takes priority)
//   ptr_o          registered Gray write pointer toward the read domain
//   addr_o         memory write address for the current cycle
//   wr_en_o        memory write enable (request accepted)
//   fifo_full_o    registered full flag
//   almost_full_o  level_o >= AF_THRESH
//   level_o        conservative fill count, 0 .. 2**ADDR_SIZE
//   overflow_o     sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module write_pointer #(
  parameter int ADDR_SIZE   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2**ADDR_SIZE - 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   rd_ptr_i,
  input  logic                 inc_i,
  input  logic                 clr_ovf_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 wr_en_o,
  output logic                 fifo_full_o,
  output logic                 almost_full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  // Gray -> binary: each binary bit is the XOR of all Gray bits above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Read-pointer synchroniser. Only rq_q[0] ever samples rd_ptr_i; the Gray
  // encoding guarantees at most one bit is in flight per read-side update.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][PW-1:0] rq_q;
  logic [PW-1:0]                  rq_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rq_q <= '0;
    end else begin
      rq_q[0] <= rd_ptr_i;
      for (int k = 1; k < SYNC_STAGES; k++) rq_q[k] <= rq_q[k-1];
    end
  end

  assign rq_s = rq_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Write pointer
  // ---------------------------------------------------------------------------
  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] full_match;

  assign wr_en_o = inc_i & ~full_q;

  assign bin_d  = bin_q + PW'(wr_en_o);
  assign gray_d = bin_d ^ (bin_d >> 1);

  // Full when the writer is exactly one lap ahead of the reader: in Gray form
  // that is the read pointer with its top two bits inverted. Comparing the
  // next-state pointer makes full rise on the edge that takes the last slot.
  assign full_match = {~rq_s[PW-1:PW-2], rq_s[PW-3:0]};
  assign full_d     = (gray_d == full_match);

  // Set beats clear; a rejected write leaves the pointers alone (wr_en_o=0).
  always_comb begin
    ovf_d = ovf_q;
    if (inc_i && full_q) ovf_d = 1'b1;
    else if (clr_ovf_i)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The synchronised read pointer lags the real one, so level_o can
  // only overstate occupancy, never understate it.
  // ---------------------------------------------------------------------------
  assign ptr_o         = gray_q;
  assign addr_o        = bin_q[ADDR_SIZE-1:0];
  assign fifo_full_o   = full_q;
  assign overflow_o    = ovf_q;
  assign level_o       = bin_q - gray2bin(rq_s);
  assign almost_full_o = (level_o >= AF_T);

endmodule

// File: tb/tb_write_pointer.sv
// Bench for write_pointer at ADDR_SIZE=3, SYNC_STAGES=2, AF_THRESH=6.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_write_pointer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] rd_ptr_i;
  logic       inc_i;
  logic       clr_ovf_i;
  logic [3:0] ptr_o;
  logic [2:0] addr_o;
  logic       wr_en_o;
  logic       fifo_full_o;
  logic       almost_full_o;
  logic [3:0] level_o;
  logic       overflow_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] ptr;
    logic [3:0] lvl;
    logic       full;
    logic       af;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Gray sequence for writes 1..8 from an empty FIFO.
  logic [3:0] gseq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                           4'b0111, 4'b0101, 4'b0100, 4'b1100};

  write_pointer #(.ADDR_SIZE(3), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_ptr_i(rd_ptr_i), .inc_i(inc_i),
    .clr_ovf_i(clr_ovf_i), .ptr_o(ptr_o), .addr_o(addr_o), .wr_en_o(wr_en_o),
    .fifo_full_o(fifo_full_o), .almost_full_o(almost_full_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Pure stimulus: n accepted-or-not write cycles with no checking.
  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      inc_i = 1'b1;
      @(negedge clk_i);
    end
    inc_i = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic hard_reset;
    rst_i = 1'b0; inc_i = 1'b0; clr_ovf_i = 1'b0; rd_ptr_i = 4'b0000;
    #2;
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b0; inc_i = 1'b0; clr_ovf_i = 1'b0; rd_ptr_i = 4'b0000;
    #12;
    vectors++;
    if ({ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, almost_full_o, overflow_o} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state: ptr=%b addr=%b full=%b lvl=%0d wen=%b af=%b ovf=%b, all required 0",
               ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, almost_full_o, overflow_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_n(3);
    vectors++;
    if ({ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, overflow_o} !== 14'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: ptr=%b addr=%b full=%b lvl=%0d wen=%b ovf=%b, all required 0",
               ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, overflow_o);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      inc_i = 1'b1;
      #1;
      vectors++;
      if (wr_en_o !== 1'b1 || addr_o !== 3'(i)) begin
        miscompares++;
        $display("FAIL fill_accept[%0d]: wen=%b addr=%0d, required wen=1 addr=%0d", i, wr_en_o, addr_o, i);
      end
      sb.push_back('{ptr: gseq[i], lvl: 4'(i + 1), full: (i == 7), af: (i + 1 >= 6)});
      @(negedge clk_i);
      e = sb.pop_front();
      vectors++;
      if (ptr_o !== e.ptr || level_o !== e.lvl || fifo_full_o !== e.full || almost_full_o !== e.af) begin
        miscompares++;
        $display("FAIL fill_state[%0d]: ptr=%b lvl=%0d full=%b af=%b, required ptr=%b lvl=%0d full=%b af=%b",
                 i, ptr_o, level_o, fifo_full_o, almost_full_o, e.ptr, e.lvl, e.full, e.af);
      end
    end
    inc_i = 1'b0;
  endtask

  task automatic test_overflow;
    inc_i = 1'b1;
    #1;
    vectors++;
    if (wr_en_o !== 1'b0) begin
      miscompares++;
      $display("FAIL blocked_wen: got %b, required 0", wr_en_o);
    end
    @(negedge clk_i);
    inc_i = 1'b0;
    vectors++;
    if (ptr_o !== 4'b1100 || overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: ptr=%b ovf=%b, required ptr=1100 ovf=1", ptr_o, overflow_o);
    end
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %b, required 0", overflow_o);
    end
    inc_i = 1'b1;
    @(negedge clk_i);
    inc_i = 1'b0; clr_ovf_i = 1'b0;
    vectors++;
    if (overflow_o !== 1'b1 || ptr_o !== 4'b1100) begin
      miscompares++;
      $display("FAIL overflow_set_wins: ovf=%b ptr=%b, required ovf=1 ptr=1100", overflow_o, ptr_o);
    end
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0;
  endtask

  task automatic test_drain;
    logic [2:0] fexp;
    rd_ptr_i = 4'b0001;
    fexp = 3'b110;  // full still 1 after edges 1 and 2, drops on edge 3
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      vectors++;
      if (fifo_full_o !== fexp[2-k]) begin
        miscompares++;
        $display("FAIL drain_full_edge%0d: got %b, required %b", k + 1, fifo_full_o, fexp[2-k]);
      end
    end
    vectors++;
    if (level_o !== 4'd7) begin
      miscompares++;
      $display("FAIL drain_level: got %0d, required 7", level_o);
    end
    inc_i = 1'b1;
    #1;
    vectors++;
    if (wr_en_o !== 1'b1 || addr_o !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_rewrite: wen=%b addr=%0d, required wen=1 addr=0", wr_en_o, addr_o);
    end
    sb.push_back('{ptr: 4'b1101, lvl: 4'd8, full: 1'b1, af: 1'b1});
    @(negedge clk_i);
    inc_i = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (ptr_o !== e.ptr || level_o !== e.lvl || fifo_full_o !== e.full) begin
      miscompares++;
      $display("FAIL drain_refull: ptr=%b lvl=%0d full=%b, required ptr=%b lvl=%0d full=%b",
               ptr_o, level_o, fifo_full_o, e.ptr, e.lvl, e.full);
    end
  endtask

  task automatic test_reset_mid;
    inc_i = 1'b1;            // blocked write to make overflow non-zero
    @(negedge clk_i);
    #2;
    inc_i = 1'b0;
    rst_i = 1'b0;            // no clock edge between here and the check
    #1;
    vectors++;
    if ({ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, almost_full_o, overflow_o} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset: ptr=%b addr=%b full=%b lvl=%0d wen=%b af=%b ovf=%b, all required 0",
               ptr_o, addr_o, fifo_full_o, level_o, wr_en_o, almost_full_o, overflow_o);
    end
    rst_i = 1'b1;
    rd_ptr_i = 4'b0000;
    @(negedge clk_i);
  endtask

  task automatic test_track;
    logic [3:0] hist [4];
    int fulls;
    hard_reset();
    fulls = 0;
    for (int k = 0; k < 4; k++) hist[k] = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      rd_ptr_i = hist[3];
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ptr_o;
      inc_i = 1'b1;
      #1;
      vectors++;
      if (wr_en_o !== 1'b1 || addr_o !== 3'(i % 8)) begin
        miscompares++;
        $display("FAIL track_accept[%0d]: wen=%b addr=%0d, required wen=1 addr=%0d", i, wr_en_o, addr_o, i % 8);
      end
      sb.push_back('{ptr: gray((i + 1) % 16), lvl: 4'd0, full: 1'b0, af: 1'b0});
      @(negedge clk_i);
      e = sb.pop_front();
      vectors++;
      if (ptr_o !== e.ptr) begin
        miscompares++;
        $display("FAIL track_ptr[%0d]: got %b, required %b", i, ptr_o, e.ptr);
      end
      if (fifo_full_o !== 1'b0) fulls++;
    end
    inc_i = 1'b0;
    vectors++;
    if (fulls != 0) begin
      miscompares++;
      $display("FAIL track_never_full: full seen %0d times, required 0", fulls);
    end
  endtask

  task automatic test_wrap_full;
    hard_reset();
    write_n(7);                 // bin 7
    rd_ptr_i = gray(7);
    idle_n(3);
    write_n(1);                 // bin 8
    rd_ptr_i = 4'b1100;         // reader at bin 8
    idle_n(3);
    write_n(7);                 // bin 15
    vectors++;
    if (level_o !== 4'd7 || fifo_full_o !== 1'b0 || ptr_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_pre: lvl=%0d full=%b ptr=%b, required lvl=7 full=0 ptr=1000",
               level_o, fifo_full_o, ptr_o);
    end
    inc_i = 1'b1;
    #1;
    vectors++;
    if (wr_en_o !== 1'b1 || addr_o !== 3'd7) begin
      miscompares++;
      $display("FAIL wrap_accept: wen=%b addr=%0d, required wen=1 addr=7", wr_en_o, addr_o);
    end
    sb.push_back('{ptr: 4'b0000, lvl: 4'd8, full: 1'b1, af: 1'b1});
    @(negedge clk_i);
    inc_i = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (ptr_o !== e.ptr || fifo_full_o !== e.full || level_o !== e.lvl || almost_full_o !== e.af) begin
      miscompares++;
      $display("FAIL wrap_full: ptr=%b full=%b lvl=%0d af=%b, required ptr=%b full=%b lvl=%0d af=%b",
               ptr_o, fifo_full_o, level_o, almost_full_o, e.ptr, e.full, e.lvl, e.af);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_track();
    test_wrap_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/write_pointer.md
Name: write_pointer

Overview:
- Write-side pointer and flag controller for the dual-clock FIFO. It is the counterpart of the read-side pointer block.
- Runs entirely in the write clock domain.
- Keeps the binary write address and the Gray write pointer that is exported to the read domain.
- Synchronises the read domain's Gray pointer and produces the full, almost-full, fill-level and sticky overflow indications for the ADC sample writer.

Parameters:
- ADDR_SIZE, 8: FIFO address width; depth = 2**ADDR_SIZE; legal range ≥2.
- SYNC_STAGES, 2: flop stages on the incoming read pointer; legal range ≥2.
- AF_THRESH, 2**ADDR_SIZE-4: level at or above which almost_full_o asserts.

Ports:
- clk_i  input  1  write-domain clock.
- rst_i  input  1  asynchronous, active-low reset.
- rd_ptr_i  input  ADDR_SIZE+1  Gray read pointer from the read domain; asynchronous to clk_i.
- inc_i  input  1  write request; one entry per cycle.
- clr_ovf_i  input  1  clears overflow_o.
- ptr_o  output  ADDR_SIZE+1  Gray write pointer, registered, sent to the read domain.
- addr_o  output  ADDR_SIZE  memory write address for the current cycle.
- wr_en_o  output  1  memory write enable.
- fifo_full_o  output  1  FIFO full, registered.
- almost_full_o  output  1  level_o ≥ AF_THRESH.
- level_o  output  ADDR_SIZE+1  conservative fill count, range 0..2**ADDR_SIZE.
- overflow_o  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (rst_i low, asynchronous):
  - bin counter, Gray counter, all sync flops, fifo_full_o and overflow_o go to 0.
  - Consequently ptr_o=0, addr_o=0, level_o=0, wr_en_o=0, almost_full_o=0 (because AF_THRESH>0).
  - Reset asserted mid-operation discards all state immediately; there is no drain.
- Synchroniser:
  - rd_ptr_i passes through a SYNC_STAGES-deep flop chain: rq[0] ← rd_ptr_i, rq[k] ← rq[k-1].
  - rq_s is the last stage. No other logic samples rd_ptr_i directly.
- Accept: wr_en_o = inc_i & ~fifo_full_o, combinational.
  - When wr_en_o=1, the data is written at addr_o = bin[ADDR_SIZE-1:0] in the same cycle.
- Next-state:
  - bin_n = bin + wr_en_o, modulo 2**(ADDR_SIZE+1).
  - gray_n = bin_n ^ (bin_n >> 1).
  - Both bin and Gray registers load their _n values every clock.
  - ptr_o equals bin2gray(bin) at all times; there is no extra cycle of lag.
  - ptr_o changes by exactly one bit per accepted write.
- Full:
  - fifo_full_o ← (gray_n == {~rq_s[ADDR_SIZE:ADDR_SIZE-1], rq_s[ADDR_SIZE-2:0]}).
  - Full asserts on the clock edge that accepts the final free entry.
  - Full deasserts SYNC_STAGES+1 edges after rd_ptr_i advances, which is pessimistic and safe.
- Level:
  - level_o = bin − gray2bin(rq_s), modulo 2**(ADDR_SIZE+1), combinational from registers.
  - It may overstate the true fill while read pointer updates are in flight; it never understates it.
  - almost_full_o = (level_o ≥ AF_THRESH), combinational.
- Overflow:
  - overflow_o ← 1 when inc_i & fifo_full_o.
  - Otherwise overflow_o ← 0 when clr_ovf_i.
  - Set and clear in the same cycle: set wins.
  - A rejected write leaves the pointers unchanged.
- Wrap-around:
  - bin wraps 2**(ADDR_SIZE+1)−1 → 0 while addr_o wraps at the depth boundary.
  - The MSB/second-MSB inversion in the full compare makes full and empty distinct across wraps.
- gray2bin:
  - b[ADDR_SIZE] = g[ADDR_SIZE].
  - b[i] = b[i+1] ^ g[i].

Test Plan (ADDR_SIZE=3, SYNC_STAGES=2, AF_THRESH=6, rd_ptr_i held at 0 unless stated):
- Reset then idle → ptr_o=0000, addr_o=000, fifo_full_o=0, level_o=0, wr_en_o=0; rst_i pulsed low mid-burst → all outputs 0 asynchronously, with no clock needed.
- 8 consecutive inc_i → wr_en_o=1 on each, addr_o 0..7, and ptr_o Gray sequence 0001,0011,0010,0110,0111,0101,0100,1100. Flags:
  - almost_full_o high from level 6.
  - fifo_full_o=1 on the same edge that ptr_o becomes 1100.
  - level_o=8.
- Write attempted while full → wr_en_o=0, ptr_o stays 1100, overflow_o=1 next edge. clr_ovf_i pulse → overflow_o=0. clr_ovf_i together with a blocked write → overflow_o stays 1.
- From full, set rd_ptr_i=0001 → fifo_full_o drops exactly 3 edges later, level_o reads 7, and the next write is accepted at addr_o=000.
- Reader tracks the writer with rd_ptr_i = ptr_o delayed by 4 cycles, 16 writes → ptr_o returns to 0000 after write 16, addr_o wraps 7→0 twice, and fifo_full_o never asserts.
- Reader at bin 8 (rd_ptr_i=1100) and writer at bin 15 → level_o=7, not full. One write → ptr_o=0000 and fifo_full_o=1, because the full compare {~11,00}=0000 matches.
